// File: rtl/bayer_bin_pkg.sv
// Shared types and arithmetic for the Bayer 2x2 binning stage.
// Define BAYER_BIN_LUMA_EN for weighted luma instead of the plain quad average.
package bayer_bin_pkg;

  localparam int RAW_W  = 12;
  localparam int PART_W = 16;

  typedef enum logic [1:0] {S_WAIT, S_EVEN, S_ODD} bin_state_t;

  // Even-row contribution of one quad, stored in the line buffer.
  function automatic logic [PART_W-1:0] part_sum(input logic [RAW_W-1:0] g1,
                                                 input logic [RAW_W-1:0] r);
    logic [PART_W-1:0] g1_w;
    logic [PART_W-1:0] r_w;
    g1_w = PART_W'(g1);
    r_w  = PART_W'(r);
`ifdef BAYER_BIN_LUMA_EN
    return (g1_w << 2) + g1_w + (r_w << 2);
`else
    return g1_w + r_w;
`endif
  endfunction

  // Completes the quad with the odd-row samples; the sum never exceeds 16 bits.
  function automatic logic [RAW_W-1:0] quad_gray(input logic [PART_W-1:0] p,
                                                  input logic [RAW_W-1:0]  b,
                                                  input logic [RAW_W-1:0]  g2);
    logic [17:0] s;
`ifdef BAYER_BIN_LUMA_EN
    s = 18'(p) + (18'(g2) << 2) + 18'(g2) + (18'(b) << 1);
    return RAW_W'(s >> 4);
`else
    s = 18'(p) + 18'(b) + 18'(g2);
    return RAW_W'(s >> 2);
`endif
  endfunction

endpackage

// File: rtl/pair_line_ram.sv
// Simple dual-port line buffer for even-row partial sums.
// Synchronous write; registered read that holds until the next read enable.
module pair_line_ram #(
  parameter int unsigned Depth = 640,
  parameter int unsigned Width = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/bayer_bin_gray.sv
// Bins a GR/BG Bayer stream 2x2 into grayscale, one pixel per quad on the odd row.
// Weighting selected by BAYER_BIN_LUMA_EN (see bayer_bin_pkg).
module bayer_bin_gray
  import bayer_bin_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 1280
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iFVAL,
  input  logic             iDVAL,
  input  logic [RAW_W-1:0] iRAW,
  output logic             oDVAL,
  output logic [RAW_W-1:0] oGRAY,
  output logic             oSOF,
  output logic             oSHORT_LINE
);

  localparam int unsigned OUT_WIDTH = IN_WIDTH / 2;
  localparam int unsigned COL_W     = $clog2(IN_WIDTH);
  localparam int unsigned ADDR_W    = $clog2(OUT_WIDTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IN_WIDTH - 1);

  bin_state_t        state;
  bin_state_t        cur;
  logic              fvq;
  logic [COL_W-1:0]  col;
  logic [RAW_W-1:0]  a_q;
  logic [RAW_W-1:0]  b_q;
  logic              sof_pend;

  logic              rise;
  logic              last_beat;
  logic              beat;
  logic              short_now;
  logic              ram_we;
  logic              ram_re;
  logic              out_fire;
  logic [ADDR_W-1:0] quad_addr;
  logic [PART_W-1:0] ram_rdata;

  always_comb begin
    rise      = iFVAL & ~fvq;
    // A rising edge in S_WAIT makes the same-cycle beat col 0 of the even row.
    cur       = (state == S_WAIT && rise) ? S_EVEN : state;
    last_beat = iDVAL && (col == COL_LAST);
    // The completing beat of a line still counts when iFVAL falls with it.
    beat      = (cur != S_WAIT) && iDVAL && (iFVAL || col == COL_LAST);
    short_now = (state != S_WAIT) && !iFVAL && (col != '0) && !last_beat;
    ram_we    = beat && (cur == S_EVEN) && col[0];
    ram_re    = beat && (cur == S_ODD) && !col[0];
    out_fire  = beat && (cur == S_ODD) && col[0];
    quad_addr = ADDR_W'(col >> 1);
  end

  pair_line_ram #(
    .Depth (OUT_WIDTH),
    .Width (PART_W),
    .AddrW (ADDR_W)
  ) u_ram (
    .clk_i   (iCLK),
    .we_i    (ram_we),
    .waddr_i (quad_addr),
    .wdata_i (part_sum(a_q, iRAW)),
    .re_i    (ram_re),
    .raddr_i (quad_addr),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state       <= S_WAIT;
      // Track the live level so a frame already in progress is not seen as a new rise.
      fvq         <= iFVAL;
      col         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sof_pend    <= 1'b0;
      oDVAL       <= 1'b0;
      oGRAY       <= '0;
      oSOF        <= 1'b0;
      oSHORT_LINE <= 1'b0;
    end else begin
      fvq         <= iFVAL;
      oDVAL       <= out_fire;
      oSOF        <= out_fire && sof_pend;
      oSHORT_LINE <= short_now;
      if (out_fire) oGRAY <= quad_gray(ram_rdata, b_q, iRAW);

      if (state == S_WAIT && rise) sof_pend <= 1'b1;
      else if (out_fire)           sof_pend <= 1'b0;

      if (beat && cur == S_EVEN && !col[0]) a_q <= iRAW;
      if (ram_re) b_q <= iRAW;

      if (state != S_WAIT && !iFVAL) begin
        state <= S_WAIT;
        col   <= '0;
      end else begin
        state <= cur;
        if (beat) begin
          if (col == COL_LAST) begin
            col   <= '0;
            state <= (cur == S_EVEN) ? S_ODD : S_EVEN;
          end else begin
            col <= col + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bayer_bin_gray.sv
// Directed bench for bayer_bin_gray on a narrow (64 px) line.
module tb_bayer_bin_gray;

  localparam int W  = 64;
  localparam int OW = W / 2;
`ifdef BAYER_BIN_LUMA_EN
  localparam int FLAT_EXP = 243;
`else
  localparam int FLAT_EXP = 250;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fval = 1'b0;
  logic        dval = 1'b0;
  logic [11:0] raw = '0;
  logic        o_dval;
  logic [11:0] o_gray;
  logic        o_sof;
  logic        o_short;

  int tests = 0;
  int fails = 0;
  int out_cnt = 0;
  int last_gray = -1;
  bit sof_exp = 1'b0;
  int cnt0;

  bayer_bin_gray #(.IN_WIDTH(W)) dut (
    .iCLK        (clk),
    .iRST        (rst),
    .iFVAL       (fval),
    .iDVAL       (dval),
    .iRAW        (raw),
    .oDVAL       (o_dval),
    .oGRAY       (o_gray),
    .oSOF        (o_sof),
    .oSHORT_LINE (o_short)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_dval === 1'b1) begin
      out_cnt   <= out_cnt + 1;
      last_gray <= int'(o_gray);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sample(input int mode, input int seed, input int row, input int col);
    case (mode)
      0: return (row % 2 == 0) ? ((col % 2 == 0) ? 100 : 200) : ((col % 2 == 0) ? 300 : 400);
      1: return 4095;
      default: return (row * 97 + col * 53 + seed * 211 + 7) % 4096;
    endcase
  endfunction

  function automatic int exp_gray(input int g1, input int r, input int b, input int g2);
`ifdef BAYER_BIN_LUMA_EN
    return (5 * g1 + 4 * r + 5 * g2 + 2 * b) >> 4;
`else
    return (g1 + r + b + g2) >> 2;
`endif
  endfunction

  task automatic idle(input int n);
    dval = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_no_dval", o_dval, 0);
      chk("idle_no_short", o_short, 0);
    end
  endtask

  task automatic drive_row(input int mode, input int seed, input int row, input int gap,
                           input int start_col, input int end_col, input int stop_col,
                           input bit fall_last, input bit dead);
    for (int c = start_col; c < end_col; c++) begin
      if (c == stop_col) begin
        fval = 1'b0;
        dval = 1'b0;
        @(posedge clk); #1;
        chk("short_pulse", o_short, 1);
        chk("short_no_dval", o_dval, 0);
        @(posedge clk); #1;
        chk("short_one_cycle", o_short, 0);
        return;
      end
      fval = !(fall_last && c == W - 1);
      dval = 1'b1;
      raw  = 12'(sample(mode, seed, row, c));
      @(posedge clk); #1;
      if (!dead && row % 2 == 1 && c % 2 == 1) begin
        chk("dval", o_dval, 1);
        chk("gray", o_gray, exp_gray(sample(mode, seed, row - 1, c - 1),
                                     sample(mode, seed, row - 1, c),
                                     sample(mode, seed, row, c - 1),
                                     sample(mode, seed, row, c)));
        chk("sof", o_sof, sof_exp);
        sof_exp = 1'b0;
      end else begin
        chk("no_dval", o_dval, 0);
      end
      chk("no_short", o_short, 0);
      dval = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        chk("gap_idle", o_dval, 0);
      end
    end
  endtask

  task automatic drive_frame(input int mode, input int seed, input int rows, input int gap,
                             input bit pre_rise, input bit fall_last);
    sof_exp = 1'b1;
    if (pre_rise) begin
      fval = 1'b1;
      idle(2);
    end
    for (int r = 0; r < rows; r++) begin
      drive_row(mode, seed, r, gap, 0, W, -1, fall_last && r == rows - 1, 1'b0);
      if (r < rows - 1) idle(2);
    end
    fval = 1'b0;
    idle(3);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dval", o_dval, 0);
    chk("rst_gray", o_gray, 0);
    chk("rst_sof", o_sof, 0);
    chk("rst_short", o_short, 0);
    rst = 1'b0;

    // iDVAL active before the first frame: ignored
    dval = 1'b1;
    raw  = 12'd1234;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("pre_frame_no_dval", o_dval, 0);
    end
    // Rise coincides with col 0; 20 rows -> 10 output lines
    cnt0 = out_cnt;
    drive_frame(2, 1, 20, 0, 1'b0, 1'b0);
    chk("frame_out_count", out_cnt - cnt0, 10 * OW);

    // Flat frame
    cnt0 = out_cnt;
    drive_frame(0, 0, 4, 0, 1'b1, 1'b0);
    chk("flat_count", out_cnt - cnt0, 2 * OW);
    chk("flat_value", last_gray, FLAT_EXP);

    // Saturation
    drive_frame(1, 0, 4, 0, 1'b1, 1'b0);
    chk("sat_value", last_gray, 4095);

    // Gapped iDVAL
    cnt0 = out_cnt;
    drive_frame(2, 3, 4, 1, 1'b1, 1'b0);
    chk("gapped_count", out_cnt - cnt0, 2 * OW);

    // iFVAL falls with the last beat of an odd row
    cnt0 = out_cnt;
    drive_frame(2, 4, 2, 0, 1'b1, 1'b1);
    chk("fall_last_count", out_cnt - cnt0, OW);

    // Short line: iFVAL drops at col 37 of an odd row
    cnt0 = out_cnt;
    sof_exp = 1'b1;
    drive_row(2, 6, 0, 0, 0, W, -1, 1'b0, 1'b0);
    idle(2);
    drive_row(2, 6, 1, 0, 0, W, 37, 1'b0, 1'b0);
    dval = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("after_short_no_dval", o_dval, 0);
    end
    dval = 1'b0;
    chk("short_count", out_cnt - cnt0, 18);
    idle(2);
    drive_frame(0, 0, 2, 0, 1'b0, 1'b0);
    chk("after_short_value", last_gray, FLAT_EXP);

    // Reset mid-frame at row 3, col 20
    sof_exp = 1'b1;
    for (int r = 0; r < 3; r++) begin
      drive_row(2, 5, r, 0, 0, W, -1, 1'b0, 1'b0);
      idle(2);
    end
    drive_row(2, 5, 3, 0, 0, 20, -1, 1'b0, 1'b0);
    rst  = 1'b1;
    dval = 1'b1;
    raw  = 12'(sample(2, 5, 3, 20));
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_dval", o_dval, 0);
    chk("midrst_gray", o_gray, 0);
    chk("midrst_sof", o_sof, 0);
    chk("midrst_short", o_short, 0);
    cnt0 = out_cnt;
    drive_row(2, 5, 3, 0, 21, W, -1, 1'b0, 1'b1);
    for (int r = 4; r < 6; r++) begin
      idle(2);
      drive_row(2, 5, r, 0, 0, W, -1, 1'b0, 1'b1);
    end
    fval = 1'b0;
    idle(3);
    chk("midrst_dead_count", out_cnt - cnt0, 0);
    cnt0 = out_cnt;
    drive_frame(2, 9, 4, 0, 1'b0, 1'b0);
    chk("post_rst_count", out_cnt - cnt0, 2 * OW);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
